// File: rtl/wait_buffer.sv
// Wait buffer: holds decoded instructions until every source operand has been
// written back, then offers one fully-ready instruction per cycle to the
// execution units.
//
// Optional feature: define WAIT_BUFFER_OLDEST_FIRST_EN to select the eligible
// entry that was inserted earliest, using an age matrix. Without it the
// lowest-index eligible entry is selected, and an offered entry is held
// until it is accepted.
module wait_buffer #(
  parameter int unsigned NumEntries      = 4,
  parameter int unsigned NumTags         = 4,
  parameter int unsigned OperandsPerInst = 2,
  parameter int unsigned PayloadWidth    = 32,
  localparam int unsigned TagWidth       = $clog2(NumTags),
  localparam int unsigned IdxWidth       = $clog2(NumEntries)
) (
  input  logic                                     clk_i,
  input  logic                                     rst_i,
  // Insert side (from decoder / register table)
  input  logic                                     insert_valid_i,
  output logic                                     insert_ready_o,
  input  logic [TagWidth-1:0]                      insert_tag_i,
  input  logic [PayloadWidth-1:0]                  insert_payload_i,
  input  logic [OperandsPerInst-1:0]               operands_ready_i,
  input  logic [OperandsPerInst-1:0][TagWidth-1:0] operands_tag_i,
  // Writeback broadcast
  input  logic                                     eu_valid_i,
  input  logic [TagWidth-1:0]                      eu_tag_i,
  // Dispatch side
  output logic                                     disp_valid_o,
  input  logic                                     disp_ready_i,
  output logic [TagWidth-1:0]                      disp_tag_o,
  output logic [PayloadWidth-1:0]                  disp_payload_o,
  output logic                                     empty_o
);

  // ---------------------------------------------------------------------------
  // Entry storage
  // ---------------------------------------------------------------------------
  logic [NumEntries-1:0]                                     valid_q, valid_d;
  logic [NumEntries-1:0][TagWidth-1:0]                       tag_q, tag_d;
  logic [NumEntries-1:0][PayloadWidth-1:0]                   payload_q, payload_d;
  logic [NumEntries-1:0][OperandsPerInst-1:0]                op_rdy_q, op_rdy_d;
  logic [NumEntries-1:0][OperandsPerInst-1:0][TagWidth-1:0]  op_tag_q, op_tag_d;

  logic [NumEntries-1:0]      eligible;
  logic                       sel_valid;
  logic [IdxWidth-1:0]        sel_idx;
  logic [IdxWidth-1:0]        ins_idx;
  logic                       insert_fire;
  logic                       disp_fire;
  logic [OperandsPerInst-1:0] ins_rdy;

  // Eligibility uses registered operand state only, so a writeback this cycle
  // cannot make an entry dispatchable until the next cycle.
  always_comb begin
    for (int i = 0; i < int'(NumEntries); i++) begin
      eligible[i] = valid_q[i] & (&op_rdy_q[i]);
    end
  end

  // Lowest-index free entry is the insert target; looked up in registered
  // state so an entry freed by dispatch this cycle is not reused until next.
  always_comb begin
    ins_idx = '0;
    for (int i = int'(NumEntries) - 1; i >= 0; i--) begin
      if (!valid_q[i]) ins_idx = IdxWidth'(i);
    end
  end

  assign insert_ready_o = ~(&valid_q);
  assign insert_fire    = insert_valid_i & insert_ready_o;
  assign empty_o        = ~(|valid_q);

  // Operand readiness at insert, including a writeback that lands the same cycle.
  always_comb begin
    for (int o = 0; o < int'(OperandsPerInst); o++) begin
      ins_rdy[o] = operands_ready_i[o] | (eu_valid_i & (eu_tag_i == operands_tag_i[o]));
    end
  end

  // ---------------------------------------------------------------------------
  // Selection
  // ---------------------------------------------------------------------------
  assign sel_valid = |eligible;
  assign disp_fire = sel_valid & disp_ready_i;

`ifdef WAIT_BUFFER_OLDEST_FIRST_EN
  // older_q[j][i] set means entry j was inserted before entry i.
  logic [NumEntries-1:0][NumEntries-1:0] older_q, older_d;
  logic [NumEntries-1:0]                 oldest;

  // An eligible entry is oldest when no other eligible entry is older than it.
  always_comb begin
    for (int i = 0; i < int'(NumEntries); i++) begin
      oldest[i] = eligible[i];
      for (int j = 0; j < int'(NumEntries); j++) begin
        if (j != i && eligible[j] && older_q[j][i]) oldest[i] = 1'b0;
      end
    end
  end

  // Pick the single oldest eligible entry (lowest-index loop is only a tiebreak).
  always_comb begin
    sel_idx = '0;
    for (int i = int'(NumEntries) - 1; i >= 0; i--) begin
      if (oldest[i]) sel_idx = IdxWidth'(i);
    end
  end

  // New entry becomes younger than every other entry.
  always_comb begin
    older_d = older_q;
    if (insert_fire) begin
      for (int j = 0; j < int'(NumEntries); j++) begin
        if (IdxWidth'(j) != ins_idx) begin
          older_d[j][ins_idx] = 1'b1;
          older_d[ins_idx][j] = 1'b0;
        end
      end
      older_d[ins_idx][ins_idx] = 1'b0;
    end
  end

  // Age matrix register, cleared on reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      older_q <= '0;
    end else begin
      older_q <= older_d;
    end
  end
`else
  // An offered-but-stalled entry is held so the offer stays stable.
  logic                hold_q, hold_d;
  logic [IdxWidth-1:0] hold_idx_q, hold_idx_d;

  // Lowest-index eligible entry, unless a stalled offer is being held.
  always_comb begin
    sel_idx = '0;
    for (int i = int'(NumEntries) - 1; i >= 0; i--) begin
      if (eligible[i]) sel_idx = IdxWidth'(i);
    end
    if (hold_q) sel_idx = hold_idx_q;
  end

  // Hold next cycle when offering without acceptance.
  always_comb begin
    hold_d     = sel_valid & ~disp_ready_i;
    hold_idx_d = sel_idx;
  end

  // Hold register, cleared on reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      hold_q     <= 1'b0;
      hold_idx_q <= '0;
    end else begin
      hold_q     <= hold_d;
      hold_idx_q <= hold_idx_d;
    end
  end
`endif

  // Dispatch outputs are forced to zero when nothing is offered.
  always_comb begin
    disp_valid_o   = sel_valid;
    disp_tag_o     = '0;
    disp_payload_o = '0;
    if (sel_valid) begin
      disp_tag_o     = tag_q[sel_idx];
      disp_payload_o = payload_q[sel_idx];
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state: wakeup, dispatch release, insert
  // ---------------------------------------------------------------------------
  always_comb begin
    valid_d   = valid_q;
    tag_d     = tag_q;
    payload_d = payload_q;
    op_rdy_d  = op_rdy_q;
    op_tag_d  = op_tag_q;

    // Writeback broadcast wakes matching operands of resident entries.
    if (eu_valid_i) begin
      for (int i = 0; i < int'(NumEntries); i++) begin
        for (int o = 0; o < int'(OperandsPerInst); o++) begin
          if (valid_q[i] && (op_tag_q[i][o] == eu_tag_i)) op_rdy_d[i][o] = 1'b1;
        end
      end
    end

    if (disp_fire) valid_d[sel_idx] = 1'b0;

    // ins_idx is invalid in registered state, so it never collides with sel_idx.
    if (insert_fire) begin
      valid_d[ins_idx]   = 1'b1;
      tag_d[ins_idx]     = insert_tag_i;
      payload_d[ins_idx] = insert_payload_i;
      op_rdy_d[ins_idx]  = ins_rdy;
      op_tag_d[ins_idx]  = operands_tag_i;
    end
  end

  // Entry state register; reset drops every entry regardless of activity.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q   <= '0;
      tag_q     <= '0;
      payload_q <= '0;
      op_rdy_q  <= '0;
      op_tag_q  <= '0;
    end else begin
      valid_q   <= valid_d;
      tag_q     <= tag_d;
      payload_q <= payload_d;
      op_rdy_q  <= op_rdy_d;
      op_tag_q  <= op_tag_d;
    end
  end

endmodule

// File: tb/tb_wait_buffer.sv
// Self-checking bench for wait_buffer: directed scenarios plus random traffic,
// compared against a transaction-level model. Dispatched instructions are
// checked by a scoreboard monitor. Honours WAIT_BUFFER_OLDEST_FIRST_EN.
module tb_wait_buffer;
  localparam int NE = 4;
  localparam int NT = 4;
  localparam int OP = 2;
  localparam int PW = 32;
  localparam int TW = 2;

  logic                   clk = 1'b0;
  logic                   rst;
  logic                   insert_valid;
  logic                   insert_ready;
  logic [TW-1:0]          insert_tag;
  logic [PW-1:0]          insert_payload;
  logic [OP-1:0]          operands_ready;
  logic [OP-1:0][TW-1:0]  operands_tag;
  logic                   eu_valid;
  logic [TW-1:0]          eu_tag;
  logic                   disp_valid;
  logic                   disp_ready;
  logic [TW-1:0]          disp_tag;
  logic [PW-1:0]          disp_payload;
  logic                   empty;

  always #5 clk = ~clk;

  wait_buffer #(
    .NumEntries     (NE),
    .NumTags        (NT),
    .OperandsPerInst(OP),
    .PayloadWidth   (PW)
  ) dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .insert_valid_i  (insert_valid),
    .insert_ready_o  (insert_ready),
    .insert_tag_i    (insert_tag),
    .insert_payload_i(insert_payload),
    .operands_ready_i(operands_ready),
    .operands_tag_i  (operands_tag),
    .eu_valid_i      (eu_valid),
    .eu_tag_i        (eu_tag),
    .disp_valid_o    (disp_valid),
    .disp_ready_i    (disp_ready),
    .disp_tag_o      (disp_tag),
    .disp_payload_o  (disp_payload),
    .empty_o         (empty)
  );

  // Reference model: a bag of instructions stamped with an insertion number.
  typedef struct packed {
    logic                  v;
    logic [TW-1:0]         tag;
    logic [PW-1:0]         pl;
    logic [OP-1:0]         rdy;
    logic [OP-1:0][TW-1:0] ot;
    logic [31:0]           seq;
  } ent_t;

  ent_t                m [NE];
  logic                m_hold = 1'b0;
  int                  m_hold_idx = 0;
  logic [31:0]         m_seq = 0;
  logic [TW+PW-1:0]    exp_q[$];
  int                  errors = 0;
  int                  checks = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int m_sel();
    int s = -1;
`ifdef WAIT_BUFFER_OLDEST_FIRST_EN
    logic [31:0] best = '0;
    for (int i = 0; i < NE; i++) begin
      if (m[i].v && (&m[i].rdy) && (s < 0 || m[i].seq < best)) begin
        s    = i;
        best = m[i].seq;
      end
    end
`else
    if (m_hold) return m_hold_idx;
    for (int i = 0; i < NE; i++) begin
      if (s < 0 && m[i].v && (&m[i].rdy)) s = i;
    end
`endif
    return s;
  endfunction

  function automatic int m_free();
    for (int i = 0; i < NE; i++) if (!m[i].v) return i;
    return -1;
  endfunction

  function automatic bit m_empty();
    for (int i = 0; i < NE; i++) if (m[i].v) return 1'b0;
    return 1'b1;
  endfunction

  // One clock cycle: check outputs against the model, drive inputs, advance
  // the model, then move to 1 time unit after the next rising edge.
  task automatic step(input logic iv, input logic [TW-1:0] it, input logic [PW-1:0] ip,
                      input logic [OP-1:0] ordy, input logic [OP-1:0][TW-1:0] otag,
                      input logic ev, input logic [TW-1:0] et, input logic dr,
                      input logic rs);
    int s;
    int f;
    s = m_sel();
    f = m_free();
    chk("insert_ready", insert_ready, f >= 0);
    chk("empty", empty, m_empty());
    chk("disp_valid", disp_valid, s >= 0);
    if (s >= 0) chk("disp_tag", disp_tag, m[s].tag);

    insert_valid   = iv;
    insert_tag     = it;
    insert_payload = ip;
    operands_ready = ordy;
    operands_tag   = otag;
    eu_valid       = ev;
    eu_tag         = et;
    disp_ready     = dr;
    rst            = rs;

    if (rs) begin
      for (int i = 0; i < NE; i++) m[i].v = 1'b0;
      m_hold = 1'b0;
    end else begin
      if (s >= 0 && dr) exp_q.push_back({m[s].tag, m[s].pl});
      for (int i = 0; i < NE; i++) begin
        for (int o = 0; o < OP; o++) begin
          if (m[i].v && ev && m[i].ot[o] == et) m[i].rdy[o] = 1'b1;
        end
      end
      if (s >= 0 && dr) m[s].v = 1'b0;
      if (iv && f >= 0) begin
        m[f].v   = 1'b1;
        m[f].tag = it;
        m[f].pl  = ip;
        m[f].ot  = otag;
        for (int o = 0; o < OP; o++) m[f].rdy[o] = ordy[o] | (ev && et == otag[o]);
        m[f].seq = m_seq;
        m_seq++;
      end
      m_hold     = (s >= 0) && !dr;
      m_hold_idx = s;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input logic dr);
    step(1'b0, '0, '0, '0, '0, 1'b0, '0, dr, 1'b0);
  endtask

  task automatic ins(input logic [TW-1:0] it, input logic [PW-1:0] ip,
                     input logic [OP-1:0] ordy, input logic [TW-1:0] wt, input logic dr);
    step(1'b1, it, ip, ordy, {wt, wt}, 1'b0, '0, dr, 1'b0);
  endtask

  task automatic wake(input logic [TW-1:0] et, input logic dr);
    step(1'b0, '0, '0, '0, '0, 1'b1, et, dr, 1'b0);
  endtask

  task automatic do_reset();
    step(1'b0, '0, '0, '0, '0, 1'b0, '0, 1'b0, 1'b1);
    idle(1'b0);
  endtask

  // Scoreboard monitor: every accepted dispatch must match the next expected one.
  always @(negedge clk) begin
    if (disp_valid && disp_ready && !rst) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected: got tag=%0h payload=%0h expected no dispatch",
                 disp_tag, disp_payload);
      end else begin
        logic [TW+PW-1:0] e;
        e = exp_q.pop_front();
        if ({disp_tag, disp_payload} !== e) begin
          errors++;
          $display("FAIL sb_dispatch: got tag=%0h payload=%0h expected tag=%0h payload=%0h",
                   disp_tag, disp_payload, e[TW+PW-1:PW], e[PW-1:0]);
        end
      end
    end
  end

  initial begin
    for (int i = 0; i < NE; i++) m[i] = '0;
    rst = 1'b1; insert_valid = 1'b0; insert_tag = '0; insert_payload = '0;
    operands_ready = '0; operands_tag = '0; eu_valid = 1'b0; eu_tag = '0; disp_ready = 1'b0;
    @(posedge clk);
    #1;
    do_reset();

    // Reset values
    chk("rst_insert_ready", insert_ready, 1);
    chk("rst_disp_valid", disp_valid, 0);
    chk("rst_empty", empty, 1);
    chk("rst_disp_tag", disp_tag, 0);
    chk("rst_disp_payload", disp_payload, 0);

    // All-ready insert dispatches one cycle later, then the buffer is empty
    ins(2'd2, 32'hA5A5_0002, 2'b11, 2'd0, 1'b1);
    chk("ready_ins_disp_valid", disp_valid, 1);
    chk("ready_ins_disp_tag", disp_tag, 2);
    idle(1'b1);
    chk("ready_ins_empty_after", empty, 1);

    // Wait on tag 3, woken by writeback
    ins(2'd1, 32'h0000_1111, 2'b00, 2'd3, 1'b1);
    chk("wait_not_eligible", disp_valid, 0);
    wake(2'd3, 1'b1);
    chk("wake_disp_valid", disp_valid, 1);
    chk("wake_disp_tag", disp_tag, 1);
    idle(1'b1);

    // Writeback in the same cycle as insert
    step(1'b1, 2'd0, 32'h0000_2222, 2'b00, {2'd3, 2'd3}, 1'b1, 2'd3, 1'b1, 1'b0);
    chk("bypass_disp_valid", disp_valid, 1);
    chk("bypass_disp_tag", disp_tag, 0);
    idle(1'b1);
    chk("bypass_empty", empty, 1);

    // Full buffer: freed entry is not reused in the same cycle
    for (int i = 0; i < NE; i++) ins(TW'(i), 32'h3000_0000 + i, 2'b00, TW'(i), 1'b0);
    chk("full_insert_ready", insert_ready, 0);
    step(1'b1, 2'd3, 32'h3333_0003, 2'b11, '0, 1'b1, 2'd0, 1'b1, 1'b0);
    chk("full_disp_valid", disp_valid, 1);
    step(1'b1, 2'd3, 32'h3333_0003, 2'b11, '0, 1'b0, '0, 1'b1, 1'b0);
    chk("freed_insert_ready", insert_ready, 1);
    step(1'b1, 2'd3, 32'h3333_0003, 2'b11, '0, 1'b0, '0, 1'b0, 1'b0);
    chk("refill_insert_ready", insert_ready, 0);
    chk("refill_disp_tag", disp_tag, 3);
    do_reset();

    // Selection order: tag 0 in entry 1 is older than tag 1 in entry 0
    ins(2'd3, 32'h4000_0003, 2'b00, 2'd2, 1'b0);
    ins(2'd0, 32'h4000_0000, 2'b00, 2'd1, 1'b0);
    wake(2'd2, 1'b0);
    idle(1'b1);
    ins(2'd1, 32'h4000_0001, 2'b00, 2'd1, 1'b0);
    wake(2'd1, 1'b0);
`ifdef WAIT_BUFFER_OLDEST_FIRST_EN
    chk("order_first", disp_tag, 0);
    idle(1'b1);
    chk("order_second", disp_tag, 1);
`else
    chk("order_first", disp_tag, 1);
    idle(1'b1);
    chk("order_second", disp_tag, 0);
`endif
    idle(1'b1);
    chk("order_empty", empty, 1);

    // Reset mid-operation with a pending writeback
    for (int i = 0; i < 3; i++) ins(TW'(i), 32'h5000_0000 + i, 2'b00, 2'd2, 1'b0);
    step(1'b0, '0, '0, '0, '0, 1'b1, 2'd2, 1'b0, 1'b1);
    chk("midrst_empty", empty, 1);
    chk("midrst_disp_valid", disp_valid, 0);
    idle(1'b0);
    chk("midrst_disp_valid_after", disp_valid, 0);
    chk("midrst_empty_after", empty, 1);

    // Random traffic
    for (int c = 0; c < 3000; c++) begin
      logic rs;
      rs = ($urandom_range(0, 249) == 0);
      step($urandom_range(0, 2) != 0, TW'($urandom), $urandom, OP'($urandom),
           (OP*TW)'($urandom), $urandom_range(0, 1) == 1, TW'($urandom),
           !rs && ($urandom_range(0, 9) < 7), rs);
    end
    idle(1'b0);

    chk("sb_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/wait_buffer.md
WAIT_BUFFER -- requirements
Module: wait_buffer

Interface
REQ-001 The block SHALL have the parameter NumEntries, default 4, as the number of buffered instructions (power of two, >=2).
REQ-002 The block SHALL have the parameter NumTags, default 4, as the number of distinct producer tags; TagWidth = $clog2(NumTags).
REQ-003 The block SHALL have the parameter OperandsPerInst, default 2, as the number of source operands per instruction.
REQ-004 The block SHALL have the parameter PayloadWidth, default 32, as the width of the opaque instruction payload.
REQ-005 The block SHALL use one clock; reset is synchronous and active-high.
REQ-006 The block SHALL have port clk_i, input, 1 bit: clock, rising edge.
REQ-007 The block SHALL have port rst_i, input, 1 bit: synchronous active-high reset.
REQ-008 The block SHALL have port insert_valid_i, input, 1 bit: decoder offers an instruction.
REQ-009 The block SHALL have port insert_ready_o, output, 1 bit: buffer accepts the offered instruction.
REQ-010 The block SHALL have port insert_tag_i, input, TagWidth bits: tag of the instruction's result.
REQ-011 The block SHALL have port insert_payload_i, input, PayloadWidth bits: opaque instruction data.
REQ-012 The block SHALL have port operands_ready_i, input, OperandsPerInst bits: per-operand ready flag from the register table.
REQ-013 The block SHALL have port operands_tag_i, input, OperandsPerInst x TagWidth bits: producer tag of each not-ready operand.
REQ-014 The block SHALL have port eu_valid_i, input, 1 bit: an execution unit writes back this cycle.
REQ-015 The block SHALL have port eu_tag_i, input, TagWidth bits: tag being written back.
REQ-016 The block SHALL have port disp_valid_o, output, 1 bit: a fully-ready instruction is offered.
REQ-017 The block SHALL have port disp_ready_i, input, 1 bit: the execution units accept the offered instruction.
REQ-018 The block SHALL have port disp_tag_o, output, TagWidth bits: tag of the dispatched instruction.
REQ-019 The block SHALL have port disp_payload_o, output, PayloadWidth bits: payload of the dispatched instruction.
REQ-020 The block SHALL have port empty_o, output, 1 bit: no valid entries.

Function
REQ-021 Each entry SHALL hold: valid, tag, payload, and per-operand ready and tag fields.
REQ-022 insert_ready_o SHALL be 1 when at least one entry is invalid in the registered state. It SHALL be independent of disp_ready_i and of insert_valid_i.
REQ-023 On insert_valid_i && insert_ready_o, the instruction SHALL be written to the lowest-index invalid entry, valid the next cycle.
REQ-024 An operand stored at insert SHALL be ready if operands_ready_i[op] is 1, or if eu_valid_i is 1 and eu_tag_i equals operands_tag_i[op] in the same cycle.
REQ-025 Each cycle eu_valid_i is 1, every valid entry's not-ready operand whose tag equals eu_tag_i SHALL become ready the next cycle.
REQ-026 An entry SHALL be eligible when it is valid and all its operands are registered ready. An operand becoming ready from eu_valid_i is not eligible until the next cycle.
REQ-027 disp_valid_o SHALL be 1 iff at least one entry is eligible. disp_tag_o and disp_payload_o SHALL come from the selected entry and be combinational from registered state only.
REQ-028 On disp_valid_o && disp_ready_i, the selected entry SHALL be invalid the next cycle.
REQ-029 While disp_valid_o is 1 and disp_ready_i is 0, the offered entry SHALL stay unchanged unless an older entry becomes eligible (oldest-first mode only).
REQ-030 Insert and dispatch in the same cycle SHALL both complete. A freed entry SHALL NOT be reused in that same cycle.
REQ-031 empty_o SHALL be 1 iff no entry is valid in the registered state.
REQ-032 Latency from insert of an all-ready instruction to disp_valid_o SHALL be exactly 1 cycle.

Reset
REQ-033 While rst_i is 1 at a clock edge, all entries SHALL become invalid (including mid-operation), with age state cleared.
REQ-034 Reset output values: insert_ready_o=1, disp_valid_o=0, empty_o=1, disp_tag_o=0, disp_payload_o=0.

Configuration
REQ-035 With macro WAIT_BUFFER_OLDEST_FIRST_EN defined, selection SHALL pick the eligible entry inserted earliest, tracked by an NumEntries x NumEntries age matrix updated on insert.
REQ-036 Without WAIT_BUFFER_OLDEST_FIRST_EN, selection SHALL pick the lowest-index eligible entry, and no age state SHALL exist.

Verification
REQ-037 After reset, insert tag 2 with operands_ready=2'b11 and disp_ready_i=1 -> disp_valid_o=1 and disp_tag_o=2 one cycle later; empty_o=1 the following cycle.
REQ-038 Insert tag 1 waiting on tag 3, then eu_valid_i=1 with eu_tag_i=3 -> disp_valid_o rises the cycle after the writeback, with disp_tag_o=1.
REQ-039 Insert with operand tag 3 in the same cycle as eu_valid_i=1, eu_tag_i=3 -> entry stored ready, dispatched next cycle.
REQ-040 Fill all 4 entries with operands not ready -> insert_ready_o=0; dispatch one entry with a simultaneous insert offer -> the insert is not accepted that cycle and is accepted the next cycle.
REQ-041 With the macro defined, insert tag 0 into entry 1, then tag 1 into entry 0, and make both ready together -> tag 0 is dispatched first; without the macro -> tag 1 is dispatched first.
REQ-042 Assert rst_i with 3 valid entries and disp_ready_i=0 -> the next cycle empty_o=1, disp_valid_o=0, and a pending eu_valid_i has no effect.
